// File: rtl/measurement_display_ctrl.sv
// measurement_display_ctrl
//
// Selects, holds, tracks the minimum of, or scans a set of sampled measurement
// channels and presents one registered value for display, with a low-value
// proximity alarm that has hysteresis and a consecutive-sample qualifier.
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset_n       asynchronous active-low reset
//   ch_data       NUM_CH packed samples, channel i at [i*DATA_W +: DATA_W]
//   sample_strobe one-cycle pulse, ch_data valid
//   ch_sel        user channel select; out-of-range values select channel 0
//   mode          00 LIVE, 01 HOLD, 10 PEAK, 11 SCAN
//   capture       one-cycle button pulse (debounced upstream)
//   disp_data     registered display value
//   disp_ch       channel whose value is displayed
//   disp_valid    one-cycle pulse when disp_data was just loaded
//   state         current mode register, same encoding as mode
//   blank         PEAK with an empty (all-ones) min register for disp_ch
//   alarm         proximity alarm

module measurement_display_ctrl #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_W       = 13,
  parameter int unsigned SCAN_DIV     = 8,
  parameter int unsigned ALARM_THRESH = 500,
  parameter int unsigned ALARM_HYST   = 20,
  parameter int unsigned ALARM_COUNT  = 4,
  localparam int unsigned CH_W        = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     sample_strobe,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic [1:0]               mode,
  input  logic                     capture,
  output logic [DATA_W-1:0]        disp_data,
  output logic [CH_W-1:0]          disp_ch,
  output logic                     disp_valid,
  output logic [1:0]               state,
  output logic                     blank,
  output logic                     alarm
);

  localparam int unsigned SC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ACNT_W = $clog2(ALARM_COUNT + 1);

  // Thresholds are held one bit wider than the data so THRESH + HYST never wraps.
  localparam logic [DATA_W:0] ThreshX = (DATA_W + 1)'(ALARM_THRESH);
  localparam logic [DATA_W:0] ClearX  = ThreshX + (DATA_W + 1)'(ALARM_HYST);

  typedef enum logic [1:0] {
    StLive = 2'b00,
    StHold = 2'b01,
    StPeak = 2'b10,
    StScan = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic [CH_W-1:0]     disp_ch_q, disp_ch_d;
  logic                disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0]   min_q [NUM_CH];
  logic [DATA_W-1:0]   min_d [NUM_CH];
  logic [CH_W-1:0]     scan_idx_q, scan_idx_d;
  logic [SC_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic                scan_pause_q, scan_pause_d;
  logic [ACNT_W-1:0]   acnt_q, acnt_d;
  logic                alarm_q, alarm_d;

  logic [DATA_W-1:0]   samples [NUM_CH];
  logic [CH_W-1:0]     sel;
  logic                entering;
  logic                cap_ok;
  logic [DATA_W:0]     alarm_val;

  // Unpack the sample bus once so every consumer indexes an array.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      samples[i] = ch_data[i*DATA_W +: DATA_W];
    end
  end

  assign sel = (32'(ch_sel) < NUM_CH) ? ch_sel : '0;

  always_comb begin
    state_d      = state_e'(mode);
    disp_data_d  = disp_data_q;
    disp_ch_d    = disp_ch_q;
    disp_valid_d = 1'b0;
    min_d        = min_q;
    scan_idx_d   = scan_idx_q;
    scan_cnt_d   = scan_cnt_q;
    scan_pause_d = scan_pause_q;
    acnt_d       = acnt_q;
    alarm_d      = alarm_q;

    // A mode change is in flight this cycle; the button is not trusted yet.
    entering = (state_d != state_q);
    cap_ok   = capture && !entering;

    // Minimum tracking runs on every strobe regardless of mode.
    if (sample_strobe) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (samples[i] < min_q[i]) begin
          min_d[i] = samples[i];
        end
      end
    end

    // Capture in PEAK wins over a coincident sample on the selected channel.
    if ((state_d == StPeak) && cap_ok) begin
      min_d[sel] = '1;
    end

    unique case (state_d)
      StLive: begin
        disp_ch_d = sel;
        if (sample_strobe) begin
          disp_data_d  = samples[sel];
          disp_valid_d = 1'b1;
        end
      end
      StHold: begin
        if (entering || cap_ok) begin
          disp_ch_d    = sel;
          disp_data_d  = samples[sel];
          disp_valid_d = 1'b1;
        end
      end
      StPeak: begin
        disp_ch_d = sel;
        if (sample_strobe && !cap_ok) begin
          disp_data_d  = min_d[sel];
          disp_valid_d = 1'b1;
        end
      end
      StScan: begin
        if (entering) begin
          scan_idx_d   = '0;
          scan_cnt_d   = '0;
          scan_pause_d = 1'b0;
          disp_ch_d    = '0;
        end else begin
          if (sample_strobe) begin
            // disp_ch follows the channel whose value was actually loaded.
            disp_ch_d    = scan_idx_q;
            disp_data_d  = samples[scan_idx_q];
            disp_valid_d = 1'b1;
            if (!scan_pause_q) begin
              if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
                scan_cnt_d = '0;
                scan_idx_d = (scan_idx_q == CH_W'(NUM_CH - 1)) ? '0 : scan_idx_q + 1'b1;
              end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
              end
            end
          end
          if (cap_ok) begin
            scan_pause_d = !scan_pause_q;
          end
        end
      end
      default: ;
    endcase

    // Alarm watches the channel on display as of this cycle; a channel switch
    // discards any accumulated evidence.
    alarm_val = {1'b0, samples[disp_ch_q]};
    if (disp_ch_d != disp_ch_q) begin
      acnt_d  = '0;
      alarm_d = 1'b0;
    end else if (sample_strobe) begin
      if (alarm_val < ThreshX) begin
        if (acnt_q < ACNT_W'(ALARM_COUNT)) begin
          acnt_d = acnt_q + 1'b1;
        end
        if (acnt_d >= ACNT_W'(ALARM_COUNT)) begin
          alarm_d = 1'b1;
        end
      end else begin
        acnt_d = '0;
        if (alarm_val >= ClearX) begin
          alarm_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StLive;
      disp_data_q  <= '0;
      disp_ch_q    <= '0;
      disp_valid_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        min_q[i] <= '1;
      end
      scan_idx_q   <= '0;
      scan_cnt_q   <= '0;
      scan_pause_q <= 1'b0;
      acnt_q       <= '0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_data_q  <= disp_data_d;
      disp_ch_q    <= disp_ch_d;
      disp_valid_q <= disp_valid_d;
      for (int i = 0; i < NUM_CH; i++) begin
        min_q[i] <= min_d[i];
      end
      scan_idx_q   <= scan_idx_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_pause_q <= scan_pause_d;
      acnt_q       <= acnt_d;
      alarm_q      <= alarm_d;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_ch    = disp_ch_q;
  assign disp_valid = disp_valid_q;
  assign state      = state_q;
  assign alarm      = alarm_q;
  assign blank      = (state_q == StPeak) && (min_q[disp_ch_q] == '1);

endmodule

// File: tb/tb_measurement_display_ctrl.sv
// Bench for measurement_display_ctrl: directed scenarios plus a randomized run,
// all checked against a behavioural model with a queue of expected loads.

module tb_measurement_display_ctrl;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 13;
  localparam int SCAN_DIV = 2;
  localparam int TH       = 500;
  localparam int HY       = 20;
  localparam int AC       = 4;
  localparam int CH_W     = 2;
  localparam int ALL1     = (1 << DATA_W) - 1;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     sample_strobe;
  logic [CH_W-1:0]          ch_sel;
  logic [1:0]               mode;
  logic                     capture;
  logic [DATA_W-1:0]        disp_data;
  logic [CH_W-1:0]          disp_ch;
  logic                     disp_valid;
  logic [1:0]               state;
  logic                     blank;
  logic                     alarm;

  always #5 clk = ~clk;

  measurement_display_ctrl #(
    .NUM_CH      (NUM_CH),
    .DATA_W      (DATA_W),
    .SCAN_DIV    (SCAN_DIV),
    .ALARM_THRESH(TH),
    .ALARM_HYST  (HY),
    .ALARM_COUNT (AC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ch_data      (ch_data),
    .sample_strobe(sample_strobe),
    .ch_sel       (ch_sel),
    .mode         (mode),
    .capture      (capture),
    .disp_data    (disp_data),
    .disp_ch      (disp_ch),
    .disp_valid   (disp_valid),
    .state        (state),
    .blank        (blank),
    .alarm        (alarm)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int data;
    int ch;
  } load_t;

  load_t exp_q[$];

  int m_state, m_disp_data, m_disp_ch, m_valid;
  int m_idx, m_cnt, m_pause, m_acnt, m_alarm;
  int m_min[NUM_CH];
  int smp[NUM_CH];
  int sel, new_ch, val, aval;
  bit entering, cap, load;
  load_t item;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_state = 0; m_disp_data = 0; m_disp_ch = 0; m_valid = 0;
      m_idx = 0; m_cnt = 0; m_pause = 0; m_acnt = 0; m_alarm = 0;
      for (int i = 0; i < NUM_CH; i++) m_min[i] = ALL1;
      exp_q.delete();
    end else begin
      for (int i = 0; i < NUM_CH; i++) smp[i] = int'(ch_data[i*DATA_W +: DATA_W]);
      sel      = (int'(ch_sel) < NUM_CH) ? int'(ch_sel) : 0;
      entering = (int'(mode) != m_state);
      cap      = capture && !entering;
      aval     = smp[m_disp_ch];
      new_ch   = m_disp_ch;
      load     = 0;
      val      = m_disp_data;
      if (sample_strobe) begin
        for (int i = 0; i < NUM_CH; i++) if (smp[i] < m_min[i]) m_min[i] = smp[i];
      end
      case (int'(mode))
        0: begin
          new_ch = sel;
          if (sample_strobe) begin load = 1; val = smp[sel]; end
        end
        1: begin
          if (entering || cap) begin new_ch = sel; load = 1; val = smp[sel]; end
        end
        2: begin
          new_ch = sel;
          if (cap) m_min[sel] = ALL1;
          else if (sample_strobe) begin load = 1; val = m_min[sel]; end
        end
        default: begin
          if (entering) begin
            m_idx = 0; m_cnt = 0; m_pause = 0; new_ch = 0;
          end else begin
            if (sample_strobe) begin
              load = 1; val = smp[m_idx]; new_ch = m_idx;
              if (m_pause == 0) begin
                m_cnt++;
                if (m_cnt == SCAN_DIV) begin
                  m_cnt = 0;
                  m_idx = (m_idx + 1) % NUM_CH;
                end
              end
            end
            if (cap) m_pause = (m_pause == 0) ? 1 : 0;
          end
        end
      endcase
      if (new_ch != m_disp_ch) begin
        m_acnt = 0; m_alarm = 0;
      end else if (sample_strobe) begin
        if (aval < TH) begin
          if (m_acnt < AC) m_acnt++;
          if (m_acnt >= AC) m_alarm = 1;
        end else begin
          m_acnt = 0;
          if (aval >= TH + HY) m_alarm = 0;
        end
      end
      m_valid = load ? 1 : 0;
      if (load) begin
        m_disp_data = val;
        item.data = val;
        item.ch   = new_ch;
        exp_q.push_back(item);
      end
      m_disp_ch = new_ch;
      m_state   = int'(mode);
    end
  end

  // ---------------- monitor ----------------
  load_t got;

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      check("disp_valid", 32'(disp_valid), 32'(m_valid));
      if (disp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL load_unexpected: got data %0d ch %0d, no load expected", disp_data,
                   disp_ch);
        end else begin
          got = exp_q.pop_front();
          check("load_data", 32'(disp_data), 32'(got.data));
          check("load_ch", 32'(disp_ch), 32'(got.ch));
        end
      end
      check("state", 32'(state), 32'(m_state));
      check("disp_ch", 32'(disp_ch), 32'(m_disp_ch));
      check("disp_data", 32'(disp_data), 32'(m_disp_data));
      check("alarm", 32'(alarm), 32'(m_alarm));
      check("blank", 32'(blank), (m_state == 2 && m_min[m_disp_ch] == ALL1) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ch(input int i, input int v);
    ch_data[i*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  // Drive one cycle's strobes starting just after a falling edge; returns on the next one.
  task automatic tick(input logic stb, input logic cap_in);
    sample_strobe = stb;
    capture       = cap_in;
    @(negedge clk);
    sample_strobe = 1'b0;
    capture       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_disp_data"}, 32'(disp_data), 0);
    check({tag, "_disp_ch"}, 32'(disp_ch), 0);
    check({tag, "_disp_valid"}, 32'(disp_valid), 0);
    check({tag, "_blank"}, 32'(blank), 0);
    check({tag, "_alarm"}, 32'(alarm), 0);
  endtask

  int scan_exp[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    ch_data = '0; sample_strobe = 1'b0; ch_sel = '0; mode = 2'b00; capture = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset_n = 1'b1;
    tick(0, 0);

    // LIVE
    ch_sel = 2; set_ch(2, 1234);
    tick(1, 0);
    check("live_data", 32'(disp_data), 1234);
    check("live_ch", 32'(disp_ch), 2);
    check("live_valid", 32'(disp_valid), 1);
    tick(0, 0);
    check("live_valid_drop", 32'(disp_valid), 0);

    // HOLD
    ch_sel = 0; set_ch(0, 300); mode = 2'b01;
    tick(0, 0);
    check("hold_entry_data", 32'(disp_data), 300);
    check("hold_entry_valid", 32'(disp_valid), 1);
    set_ch(0, 900);
    tick(1, 0);
    tick(1, 0);
    check("hold_ignores_strobe", 32'(disp_data), 300);
    tick(0, 1);
    check("hold_capture", 32'(disp_data), 900);

    // PEAK
    ch_sel = 1; mode = 2'b10;
    tick(0, 0);
    tick(0, 1);
    check("peak_blank_after_clear", 32'(blank), 1);
    set_ch(1, 800); tick(1, 0);
    check("peak_800", 32'(disp_data), 800);
    check("peak_unblank", 32'(blank), 0);
    set_ch(1, 450); tick(1, 0);
    check("peak_450", 32'(disp_data), 450);
    set_ch(1, 600); tick(1, 0);
    check("peak_keep_450", 32'(disp_data), 450);
    set_ch(1, 650); tick(1, 1);
    check("peak_cap_strobe_blank", 32'(blank), 1);
    check("peak_cap_strobe_noload", 32'(disp_valid), 0);
    set_ch(1, 700); tick(1, 0);
    check("peak_700", 32'(disp_data), 700);
    check("peak_700_blank", 32'(blank), 0);

    // Alarm in LIVE
    mode = 2'b00; ch_sel = 0;
    tick(0, 0);
    set_ch(0, 499);
    for (int k = 1; k <= 4; k++) begin
      tick(1, 0);
      check($sformatf("alarm_low_%0d", k), 32'(alarm), (k == 4) ? 1 : 0);
    end
    set_ch(0, 510); tick(1, 0);
    check("alarm_hyst_hold", 32'(alarm), 1);
    set_ch(0, 520); tick(1, 0);
    check("alarm_clear", 32'(alarm), 0);
    set_ch(0, 499);
    for (int k = 0; k < 3; k++) tick(1, 0);
    ch_sel = 3; set_ch(3, 499);
    tick(0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(1, 0);
      check($sformatf("alarm_after_sel_%0d", k), 32'(alarm), (k == 4) ? 1 : 0);
    end

    // SCAN
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1000 + i);
    mode = 2'b11;
    tick(0, 0);
    for (int k = 0; k < 9; k++) begin
      tick(1, 0);
      check($sformatf("scan_ch_%0d", k), 32'(disp_ch), 32'(scan_exp[k]));
      check($sformatf("scan_data_%0d", k), 32'(disp_data), 32'(1000 + scan_exp[k]));
    end
    mode = 2'b00; tick(0, 0);
    mode = 2'b11; tick(0, 0);
    for (int k = 0; k < 3; k++) tick(1, 0);
    tick(0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(1, 0);
      check($sformatf("scan_paused_%0d", k), 32'(disp_ch), 1);
    end

    // Alarm mid-SCAN, then asynchronous reset
    set_ch(1, 100);
    for (int k = 0; k < 4; k++) tick(1, 0);
    check("scan_alarm_high", 32'(alarm), 1);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk);
    reset_n = 1'b1;
    tick(1, 0);
    check("post_reset_scan_gone", 32'(state), 32'(mode == 2'b11 ? 3 : 0));

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 7) == 0) ch_sel = CH_W'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          set_ch(i, ($urandom_range(0, 1) == 1) ? $urandom_range(440, 560)
                                                 : $urandom_range(0, ALL1));
        end
      end
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    tick(0, 0);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
